// File: rtl/adder_result_stage.sv
// Registered result stage behind the 32-bit carry-select adder: 2-entry skid FIFO
// with overflow derivation and delivery statistics. Optional sticky flag: ADDER_STICKY_OVF_EN.
module adder_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] ovf_cnt
`ifdef ADDER_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  // Entry layout: {ovf, cout, sum}
  logic [WIDTH+1:0]   mem_q [2];
  logic [WIDTH+1:0]   mem_d [2];
  logic [CNT_W-1:0]   txn_cnt_q, txn_cnt_d;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic               push, pop, in_ovf;
  logic [WIDTH+1:0]   head;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign head      = mem_q[rd_ptr_q];
  assign out_sum   = head[WIDTH-1:0];
  assign out_cout  = head[WIDTH];
  assign out_ovf   = head[WIDTH+1];
  assign txn_cnt   = txn_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign in_ovf = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    mem_d     = mem_q;
    txn_cnt_d = txn_cnt_q;
    ovf_cnt_d = ovf_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {in_ovf, in_cout, in_sum};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      txn_cnt_d = txn_cnt_q + CNT_W'(1);
      if (out_ovf && (ovf_cnt_q != '1))
        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      txn_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      mem_q     <= mem_d;
      txn_cnt_q <= txn_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

`ifdef ADDER_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set is applied after clear so a same-cycle overflow pop wins.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr)         sticky_d = 1'b0;
    if (pop && out_ovf)  sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule
